cla_adder_4bit: RTL and testbench

// - 4-bit carry-lookahead adder slice with registered outputs.
// - Computes in1 + in2 + c_in using generate/propagate lookahead, with no ripple chain.
// - Exposes every internal carry, plus group P/G, so a second-level lookahead unit can

---
 rtl/cla_adder_4bit.sv | 38 +++
 tb/tb_cla_adder_4bit.sv | 77 +++++++
 2 files changed

// File: rtl/cla_adder_4bit.sv
// cla_adder_4bit: 4-bit carry-lookahead slice with registered sum, carries and group P/G
module cla_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic [4:1] carry,
  output logic       p_grp,
  output logic       g_grp
);
  logic [3:0] p, g;
  logic [4:0] c;
  logic       gg;
  assign p = in1 ^ in2;
  assign g = in1 & in2;
  // Every carry is a flat SOP of g, p and c_in; none is built from a lower carry
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign c[4] = gg | (&p & c_in);
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      carry <= '0;
      p_grp <= 1'b0;
      g_grp <= 1'b0;
    end else begin
      sum   <= p ^ c[3:0];
      carry <= c[4:1];
      p_grp <= &p;
      g_grp <= gg;
    end
  end
endmodule

// File: tb/tb_cla_adder_4bit.sv
// tb_cla_adder_4bit: directed and exhaustive checks of the registered 4-bit CLA slice
module tb_cla_adder_4bit;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in1, in2;
  logic       c_in;
  logic [3:0] sum;
  logic [4:1] carry;
  logic       p_grp, g_grp;
  int         passed = 0;
  int         total = 0;

  cla_adder_4bit dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .c_in(c_in),
    .sum(sum), .carry(carry), .p_grp(p_grp), .g_grp(g_grp)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b, input logic ci);
    rst = r; in1 = a; in2 = b; c_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  // Ripple reference: {sum, carry[4:1], p_grp, g_grp}
  function automatic logic [9:0] ref_model(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    logic [4:0] nocin;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    nocin = {1'b0, a} + {1'b0, b};
    return {s, c[4:1], (a ^ b) == 4'hF, nocin[4]};
  endfunction

  initial begin
    step(1'b1, 4'd0, 4'd0, 1'b0);
    chk("reset", {sum, carry, p_grp, g_grp}, 10'b0000_0000_0_0);
    step(1'b0, 4'd4, 4'd4, 1'b0);
    chk("4+4", {sum, carry, p_grp, g_grp}, 10'b1000_0100_0_0);
    step(1'b0, 4'd15, 4'd1, 1'b0);
    chk("15+1", {sum, carry, p_grp, g_grp}, 10'b0000_1111_0_1);
    step(1'b0, 4'd15, 4'd0, 1'b1);
    chk("15+0+1", {sum, carry, p_grp, g_grp}, 10'b0000_1111_1_0);
    step(1'b0, 4'd9, 4'd7, 1'b0);
    chk("9+7", {sum, carry, p_grp, g_grp}, 10'b0000_1111_0_1);
    step(1'b0, 4'd0, 4'd0, 1'b0);
    chk("0+0 b2b", {sum, carry, p_grp, g_grp}, 10'b0000_0000_0_0);
    step(1'b0, 4'd5, 4'd10, 1'b0);
    chk("5+10", {sum, carry, p_grp, g_grp}, 10'b1111_0000_1_0);
    step(1'b1, 4'd15, 4'd1, 1'b0);
    chk("rst over 15+1", {sum, carry, p_grp, g_grp}, 10'b0000_0000_0_0);
    step(1'b0, 4'd15, 4'd1, 1'b0);
    chk("post rst 15+1", {sum, carry, p_grp, g_grp}, 10'b0000_1111_0_1);
    for (int v = 0; v < 512; v++) begin
      logic [8:0] t;
      logic [4:0] arith;
      t = v[8:0];
      step(1'b0, t[8:5], t[4:1], t[0]);
      arith = {1'b0, t[8:5]} + {1'b0, t[4:1]} + {4'b0, t[0]};
      chk("sweep arith", {5'b0, carry[4], sum}, {5'b0, arith});
      chk("sweep ref", {sum, carry, p_grp, g_grp}, ref_model(t[8:5], t[4:1], t[0]));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
